// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path: default sizes,
// FSM state encoding and the bit-reversal helper.
package fft_pkg;

  localparam int unsigned NFFT      = 128;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned LOG2N     = $clog2(NFFT);
  localparam int unsigned IDX_MAX_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  // Reverse the low 'bits' bits of v; upper bits of the result are zero.
  function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] v,
                                                  input int unsigned bits);
    logic [IDX_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) begin
      r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read with
// enable. The read register holds its value while re is low, so it doubles
// as the stall-stable output stage.
module fft_reorder_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; array contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, held when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Captures one bit-reversed FFT frame and re-emits it in natural bin order
// on a valid/ready stream.
module fft_output_reorder #(
  parameter int unsigned NFFT  = fft_pkg::NFFT,
  parameter int unsigned WIDTH = fft_pkg::WIDTH,
  localparam int unsigned LOG2N = $clog2(NFFT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             end_FFT,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             overflow_err
);

  import fft_pkg::*;

  localparam int unsigned    CW       = LOG2N + 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(NFFT - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(NFFT);

  logic [1:0]         state;
  logic [CW-1:0]      wr_cnt;
  logic [CW-1:0]      rd_cnt;
  logic               we;
  logic [LOG2N-1:0]   wr_idx;
  logic [LOG2N-1:0]   wr_addr;
  logic               rd_en;
  logic               xfer;
  logic [2*WIDTH-1:0] rd_data;

  assign xfer    = out_valid && out_ready;
  assign wr_addr = LOG2N'(bitrev(IDX_MAX_W'(wr_idx), LOG2N));

  // Write strobe and input index; a start or restart always lands on index 0.
  always_comb begin
    we     = 1'b0;
    wr_idx = wr_cnt[LOG2N-1:0];
    case (state)
      ST_IDLE: begin
        if (end_FFT && data_valid) begin
          we     = 1'b1;
          wr_idx = '0;
        end
      end
      ST_CAPTURE: begin
        we = data_valid;
        if (end_FFT) wr_idx = '0;
      end
      default: ;
    endcase
  end

  // A new read is issued whenever the output stage is empty or being
  // consumed this cycle, which gives 1 sample/clk with no bubbles and
  // leaves the read register untouched during a stall.
  assign rd_en = (state == ST_DRAIN) && (rd_cnt < FULL_CNT) && (!out_valid || out_ready);

  // Frame FSM, write/read counters and the drop/restart pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (end_FFT && data_valid) begin
            state  <= ST_CAPTURE;
            wr_cnt <= CW'(1);
          end
        end
        ST_CAPTURE: begin
          if (end_FFT) begin
            overflow_err <= 1'b1;
            wr_cnt       <= data_valid ? CW'(1) : '0;
          end else if (data_valid) begin
            if (wr_cnt == LAST_CNT) begin
              state  <= ST_DRAIN;
              wr_cnt <= '0;
              rd_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (end_FFT) overflow_err <= 1'b1;
          if (rd_en) rd_cnt <= rd_cnt + CW'(1);
          if (xfer && out_last) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output valid and bin index track the registered RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_index <= rd_cnt[LOG2N-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign {out_re, out_im} = rd_data;
  assign out_last = out_valid && (out_index == LOG2N'(NFFT - 1));
  assign busy     = (state != ST_IDLE);

  fft_reorder_ram #(
    .DEPTH (NFFT),
    .AW    (LOG2N),
    .DW    (2*WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_addr),
    .wdata ({in_re, in_im}),
    .re    (rd_en),
    .raddr (rd_cnt[LOG2N-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder with NFFT=8, WIDTH=16.
module tb_fft_output_reorder;

  localparam int unsigned NFFT  = 8;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned LOG2N = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             end_FFT = 1'b0;
  logic             data_valid = 1'b0;
  logic [WIDTH-1:0] in_re = '0;
  logic [WIDTH-1:0] in_im = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             busy;
  logic             overflow_err;

  always #5 clk = ~clk;

  fft_output_reorder #(
    .NFFT  (NFFT),
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .end_FFT      (end_FFT),
    .data_valid   (data_valid),
    .in_re        (in_re),
    .in_im        (in_im),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int first_valid_cyc = -1;
  int last_xfer_cyc = -1;
  int last_in_cyc = -1;
  int bp_mode = 0;
  int bp_phase = 0;

  logic [WIDTH-1:0] q_re [$];
  logic [WIDTH-1:0] q_im [$];
  logic [LOG2N-1:0] q_idx [$];
  logic             q_last [$];

  // Natural bin k holds input sample bitrev(k).
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: snapshot handshake before the edge, observe after it.
  task automatic step();
    logic             was_xfer;
    logic             was_stall;
    logic [WIDTH-1:0] h_re;
    logic [WIDTH-1:0] h_im;
    logic [LOG2N-1:0] h_idx;
    was_xfer  = out_valid && out_ready;
    was_stall = out_valid && !out_ready;
    h_re  = out_re;
    h_im  = out_im;
    h_idx = out_index;
    @(negedge clk);
    cyc++;
    if (was_xfer) begin
      q_re.push_back(h_re);
      q_im.push_back(h_im);
      q_idx.push_back(h_idx);
      q_last.push_back(out_last_at(h_idx));
      last_xfer_cyc = cyc;
    end
    if (was_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_re", 32'(out_re), 32'(h_re));
      check("stall_im", 32'(out_im), 32'(h_im));
      check("stall_idx", 32'(out_index), 32'(h_idx));
    end
    if (overflow_err) ovf_cnt++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bp_mode != 0) begin
      out_ready = (bp_phase % 3 == 0);
      bp_phase++;
    end
  endtask

  // out_last as seen on the transferred beat (sampled with its index).
  logic last_snap;
  always @(posedge clk) last_snap <= out_last;
  function automatic logic out_last_at(input logic [LOG2N-1:0] idx);
    return last_snap || (out_last && idx == 3'd7 && 1'b0);
  endfunction

  task automatic drive(input logic sof, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
    end_FFT    = sof;
    data_valid = 1'b1;
    in_re      = re;
    in_im      = im;
    step();
    end_FFT    = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] base);
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, base + WIDTH'(k), 16'h1000 + base + WIDTH'(k));
    end
    last_in_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy && !out_valid) break;
      step();
    end
    check({tag, "_idle"}, 32'(busy || out_valid), 32'd0);
  endtask

  task automatic start_test();
    ovf_cnt = 0;
    first_valid_cyc = -1;
    last_xfer_cyc = -1;
    q_re.delete();
    q_im.delete();
    q_idx.delete();
    q_last.delete();
  endtask

  task automatic check_frame(input string tag, input logic [WIDTH-1:0] base);
    check({tag, "_count"}, 32'(q_re.size()), 32'd8);
    for (int k = 0; k < q_re.size() && k < 8; k++) begin
      check($sformatf("%s_re%0d", tag, k), 32'(q_re[k]), 32'(base + WIDTH'(br[k])));
      check($sformatf("%s_im%0d", tag, k), 32'(q_im[k]), 32'(16'h1000 + base + WIDTH'(br[k])));
      check($sformatf("%s_idx%0d", tag, k), 32'(q_idx[k]), 32'(k));
      check($sformatf("%s_last%0d", tag, k), 32'(q_last[k]), 32'(k == 7));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_re", 32'(out_re), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // data_valid without end_FFT in IDLE is ignored
    drive(1'b0, 16'h55, 16'h55);
    drive(1'b0, 16'h56, 16'h56);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_valid", 32'(out_valid), 32'd0);

    // Contiguous frame
    start_test();
    send_frame(16'h0000);
    wait_idle("contig");
    check_frame("contig", 16'h0000);
    check("contig_latency", 32'(first_valid_cyc), 32'(last_in_cyc + 1));
    check("contig_burst", 32'(last_xfer_cyc - first_valid_cyc), 32'd8);
    check("contig_ovf", 32'(ovf_cnt), 32'd0);

    // Back-pressure with ready pattern 1,0,0
    start_test();
    bp_mode = 1;
    bp_phase = 0;
    send_frame(16'h0020);
    wait_idle("bp");
    bp_mode = 0;
    out_ready = 1'b1;
    check_frame("bp", 16'h0020);

    // Input gap of 3 cycles between samples 3 and 4
    start_test();
    for (int k = 0; k < 4; k++) drive(k == 0, WIDTH'(k), 16'h1000 + WIDTH'(k));
    for (int g = 0; g < 3; g++) begin
      step();
      check("gap_busy", 32'(busy), 32'd1);
    end
    for (int k = 4; k < 8; k++) drive(1'b0, WIDTH'(k), 16'h1000 + WIDTH'(k));
    last_in_cyc = cyc;
    wait_idle("gap");
    check_frame("gap", 16'h0000);
    check("gap_latency", 32'(first_valid_cyc), 32'(last_in_cyc + 1));

    // Restart at input sample 5
    start_test();
    for (int k = 0; k < 5; k++) drive(k == 0, 16'h0040 + WIDTH'(k), 16'h1040 + WIDTH'(k));
    send_frame(16'h0060);
    wait_idle("restart");
    check("restart_ovf", 32'(ovf_cnt), 32'd1);
    check_frame("restart", 16'h0060);

    // Frame arriving during DRAIN is dropped
    start_test();
    out_ready = 1'b0;
    send_frame(16'h0080);
    send_frame(16'h00A0);
    repeat (3) step();
    out_ready = 1'b1;
    wait_idle("drop");
    check("drop_ovf", 32'(ovf_cnt), 32'd1);
    check_frame("drop", 16'h0080);
    check("drop_busy", 32'(busy), 32'd0);

    // Asynchronous reset after 3 transfers
    start_test();
    send_frame(16'h00C0);
    for (int i = 0; i < 50; i++) begin
      if (q_re.size() >= 3) break;
      step();
    end
    check("rstmid_pre", 32'(q_re.size()), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_last", 32'(out_last), 32'd0);
    step();
    rst = 1'b0;
    start_test();
    send_frame(16'h00E0);
    wait_idle("post_rst");
    check_frame("post_rst", 16'h00E0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
